wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL: clk  input  1  rising-edge clock; reset rst, synchronous, active-high; clock clk.
REQ-002 SHALL: rst  input  1  synchronous active-high reset.
REQ-003 SHALL: in_valid  input  1  MEM stage presents an instruction this cycle.
REQ-004 SHALL: in_ready  output  1  WB stage accepts; equals !stall.
REQ-005 SHALL: in_we  input  1  instruction writes a GPR.
REQ-006 SHALL: in_waddr  input  5  destination GPR index.
REQ-007 SHALL: in_result  input  32  ALU result, or effective address for loads.
REQ-008 SHALL: in_load  input  1  instruction is a load; mem_rdata supplies the write data.
REQ-009 SHALL: in_ldop  input  3  000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu; other codes behave as lw.
REQ-010 SHALL: mem_rdata  input  32  aligned data-memory word, valid with in_valid.
REQ-011 SHALL: stall  input  1  hazard unit freezes WB; the register holds its contents.
REQ-012 SHALL: flush  input  1  kill the entry being captured and the held entry.
REQ-013 SHALL: we / waddr / wdata  output  1/5/32  drive the register-file write port.
REQ-014 SHALL: adel  output  1  one-cycle pulse, misaligned load captured.
REQ-015 SHALL: retire_cnt  output  32  count of retired instructions.

Function
REQ-016 SHALL: capture occurs on a rising edge when in_valid=1, stall=0 and flush=0; v_q<=1; we_q, waddr_q and wdata_q are loaded in the same edge (one-cycle latency).
REQ-017 SHALL: on a rising edge with in_valid=0, stall=0 and flush=0, v_q<=0.
REQ-018 SHALL: stall=1 and flush=0 hold all stage registers unchanged.
REQ-019 SHALL: flush=1 dominates stall and capture; next cycle v_q=0, and retire_cnt and adel are not affected by the killed entries.
REQ-020 SHALL: we = v_q & we_q & (waddr_q != 0); waddr = waddr_q; wdata = wdata_q.
REQ-021 SHALL: non-load data is wdata_q = in_result.
REQ-022 SHALL: load data uses little-endian byte lanes selected by in_result[1:0].
- lb / lbu: byte at 8*addr[1:0], sign- or zero-extended.
- lh / lhu: halfword at 16*addr[1], sign- or zero-extended.
- lw: full word.
REQ-023 SHALL: a load is misaligned when it is lh/lhu with addr[0]=1, or lw with addr[1:0]!=0.
REQ-024 SHALL: a misaligned load that is captured sets we_q=0 and asserts adel for exactly the cycle after capture; the entry still counts as retired.
REQ-025 SHALL: retire_cnt increments by 1 on each rising edge where v_q=1 and stall=0 and flush=0; it wraps from 0xFFFFFFFF to 0.
REQ-026 SHALL: while stall=1, we stays asserted for the held entry; the repeated write of the same value is legal.

Reset
REQ-027 SHALL: rst=1 at a rising edge clears v_q, we_q, waddr_q, wdata_q, adel, retire_cnt and HI/LO to 0.
REQ-028 SHALL: rst dominates flush, stall and capture; an entry held mid-stall is discarded.
REQ-029 SHALL: in_ready is a pure function of stall and is not gated by rst.

Configuration
REQ-030 SHALL: macro WB_HILO_EN defined adds:
- inputs in_hilo_we (1), in_hi (32), in_lo (32);
- outputs hi and lo (32 each), registered;
- HI/LO capture under the same capture/stall/flush rules as REQ-016..REQ-019.
REQ-031 SHALL: with WB_HILO_EN undefined, these ports and registers are absent and all other behaviour is identical.

Verification
REQ-032 SHALL: reset, then ALU op in_we=1, waddr=5, result=0x12345678 -> next cycle we=1, waddr=5, wdata=0x12345678, and retire_cnt=1 one cycle later.
REQ-033 SHALL: lb at addr 0x...3 with mem_rdata=0x80FF7F01 -> wdata=0xFFFFFF80; the same with lbu -> wdata=0x00000080.
REQ-034 SHALL: lh at addr 0x...1 -> we=0, adel=1 for one cycle, retire_cnt increments.
REQ-035 SHALL: capture, then stall for 3 cycles -> outputs constant, in_ready=0, retire_cnt unchanged; after release retire_cnt +1.
REQ-036 SHALL: stall=1 and flush=1 on the same edge -> v_q=0 next cycle and we=0; in_waddr=0 with in_we=1 -> we=0.
REQ-037 SHALL: preload retire_cnt=0xFFFFFFFF via a forced value and retire one entry -> retire_cnt=0; with WB_HILO_EN, in_hi=0xA, in_lo=0xB -> hi=0xA, lo=0xB after one cycle.

Source files
------------

// File: rtl/wb_stage.sv
// Writeback stage: a single pipeline register feeding the GPR write port, with load
// lane extraction, misaligned-load detection and a retired-instruction counter.
// Define WB_HILO_EN to add HI/LO writeback alongside the GPR result.
module wb_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_we,
  input  logic [4:0]  in_waddr,
  input  logic [31:0] in_result,
  input  logic        in_load,
  input  logic [2:0]  in_ldop,
  input  logic [31:0] mem_rdata,
  input  logic        stall,
  input  logic        flush,
`ifdef WB_HILO_EN
  input  logic        in_hilo_we,
  input  logic [31:0] in_hi,
  input  logic [31:0] in_lo,
  output logic [31:0] hi,
  output logic [31:0] lo,
`endif
  output logic        we,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  output logic        adel,
  output logic [31:0] retire_cnt
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;

  localparam logic [2:0] LD_LB  = 3'b001;
  localparam logic [2:0] LD_LBU = 3'b010;
  localparam logic [2:0] LD_LH  = 3'b011;
  localparam logic [2:0] LD_LHU = 3'b100;

  logic            v_q, v_d;
  logic            we_q, we_d;
  logic [RW-1:0]   waddr_q, waddr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            adel_q, adel_d;
  logic [XLEN-1:0] retire_cnt_q, retire_cnt_d;
`ifdef WB_HILO_EN
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
`endif

  logic [7:0]      lane_b;
  logic [15:0]     lane_h;
  logic [XLEN-1:0] load_data;
  logic            misalign;
  logic            ld_misalign;

  // Little-endian lane select; unknown ldop codes fall through to lw.
  always_comb begin
    lane_b    = 8'(mem_rdata >> {in_result[1:0], 3'b000});
    lane_h    = 16'(mem_rdata >> {in_result[1], 4'b0000});
    load_data = mem_rdata;
    misalign  = (in_result[1:0] != 2'b00);
    case (in_ldop)
      LD_LB: begin
        load_data = {{24{lane_b[7]}}, lane_b};
        misalign  = 1'b0;
      end
      LD_LBU: begin
        load_data = {24'b0, lane_b};
        misalign  = 1'b0;
      end
      LD_LH: begin
        load_data = {{16{lane_h[15]}}, lane_h};
        misalign  = in_result[0];
      end
      LD_LHU: begin
        load_data = {16'b0, lane_h};
        misalign  = in_result[0];
      end
      default: begin
        load_data = mem_rdata;
        misalign  = (in_result[1:0] != 2'b00);
      end
    endcase
    ld_misalign = in_load & misalign;
  end

  // Next state: flush kills, stall freezes, otherwise capture and retire the held entry.
  always_comb begin
    v_d          = v_q;
    we_d         = we_q;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    adel_d       = 1'b0;
    retire_cnt_d = retire_cnt_q;
`ifdef WB_HILO_EN
    hi_d         = hi_q;
    lo_d         = lo_q;
`endif
    if (flush) begin
      v_d = 1'b0;
    end else if (!stall) begin
      v_d = in_valid;
      if (v_q) begin
        retire_cnt_d = retire_cnt_q + XLEN'(1);
      end
      if (in_valid) begin
        we_d    = in_we & ~ld_misalign;
        waddr_d = in_waddr;
        wdata_d = in_load ? load_data : in_result;
        adel_d  = ld_misalign;
`ifdef WB_HILO_EN
        if (in_hilo_we) begin
          hi_d = in_hi;
          lo_d = in_lo;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q          <= 1'b0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      adel_q       <= 1'b0;
      retire_cnt_q <= '0;
`ifdef WB_HILO_EN
      hi_q         <= '0;
      lo_q         <= '0;
`endif
    end else begin
      v_q          <= v_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      adel_q       <= adel_d;
      retire_cnt_q <= retire_cnt_d;
`ifdef WB_HILO_EN
      hi_q         <= hi_d;
      lo_q         <= lo_d;
`endif
    end
  end

  // Writes to r0 are suppressed at the port rather than at capture.
  assign in_ready   = ~stall;
  assign we         = v_q & we_q & (waddr_q != '0);
  assign waddr      = waddr_q;
  assign wdata      = wdata_q;
  assign adel       = adel_q;
  assign retire_cnt = retire_cnt_q;
`ifdef WB_HILO_EN
  assign hi         = hi_q;
  assign lo         = lo_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: vector table through a scoreboard queue,
// then hand-written stall/flush/reset/wrap sequences.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_we, in_load, stall, flush;
  logic        in_ready, we, adel;
  logic [4:0]  in_waddr, waddr;
  logic [2:0]  in_ldop;
  logic [31:0] in_result, mem_rdata, wdata, retire_cnt;
`ifdef WB_HILO_EN
  logic        in_hilo_we;
  logic [31:0] in_hi, in_lo, hi, lo;
`endif

  always #5 clk = ~clk;

  wb_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_we      (in_we),
    .in_waddr   (in_waddr),
    .in_result  (in_result),
    .in_load    (in_load),
    .in_ldop    (in_ldop),
    .mem_rdata  (mem_rdata),
    .stall      (stall),
    .flush      (flush),
`ifdef WB_HILO_EN
    .in_hilo_we (in_hilo_we),
    .in_hi      (in_hi),
    .in_lo      (in_lo),
    .hi         (hi),
    .lo         (lo),
`endif
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .adel       (adel),
    .retire_cnt (retire_cnt)
  );

  typedef struct {
    logic        valid;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] result;
    logic        load;
    logic [2:0]  ldop;
    logic [31:0] rdata;
    logic        e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic        e_adel;
    logic        chk_data;
  } vec_t;

  vec_t        vecs[$];
  vec_t        sb[$];
  vec_t        e;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        model_v  = 1'b0;
  logic [31:0] exp_ret  = 32'h0;
  logic [31:0] r_hold;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock: advance the reference model on the edge, then sample 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    if (rst) begin
      model_v = 1'b0;
      exp_ret = 32'h0;
    end else if (flush) begin
      model_v = 1'b0;
    end else if (!stall) begin
      if (model_v) exp_ret = exp_ret + 32'd1;
      model_v = in_valid;
    end
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_we = 1'b0; in_waddr = 5'd0; in_result = 32'h0;
    in_load = 1'b0; in_ldop = 3'd0; mem_rdata = 32'h0; stall = 1'b0; flush = 1'b0;
`ifdef WB_HILO_EN
    in_hilo_we = 1'b0; in_hi = 32'h0; in_lo = 32'h0;
`endif
  endtask

  task automatic drive(input vec_t v);
    in_valid = v.valid; in_we = v.we; in_waddr = v.waddr; in_result = v.result;
    in_load = v.load; in_ldop = v.ldop; mem_rdata = v.rdata;
  endtask

  function automatic vec_t mk(input logic valid, input logic iwe, input logic [4:0] wa,
                              input logic [31:0] res, input logic ld, input logic [2:0] op,
                              input logic [31:0] rd, input logic ewe, input logic [31:0] ewd,
                              input logic eadel, input logic cd);
    vec_t v;
    v.valid = valid; v.we = iwe; v.waddr = wa; v.result = res; v.load = ld; v.ldop = op;
    v.rdata = rd; v.e_we = ewe; v.e_waddr = wa; v.e_wdata = ewd; v.e_adel = eadel;
    v.chk_data = cd;
    return v;
  endfunction

  task automatic alu(input logic [4:0] wa, input logic [31:0] res);
    in_valid = 1'b1; in_we = 1'b1; in_waddr = wa; in_result = res;
    in_load = 1'b0; in_ldop = 3'd0; mem_rdata = 32'h0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();

    // in_ready ignores reset
    #1;
    chk("in_ready_rst", 32'(in_ready), 32'd1);
    stall = 1'b1;
    #1;
    chk("in_ready_rst_stall", 32'(in_ready), 32'd0);
    stall = 1'b0;
    cycle();
    cycle();
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_waddr", 32'(waddr), 32'd0);
    chk("rst_wdata", wdata, 32'h0);
    chk("rst_adel", 32'(adel), 32'd0);
    chk("rst_retire", retire_cnt, 32'h0);
`ifdef WB_HILO_EN
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
`endif
    rst = 1'b0;

    vecs.push_back(mk(1, 1, 5'd5,  32'h12345678, 0, 3'd0, 32'h0,        1, 32'h12345678, 0, 1));
    vecs.push_back(mk(1, 1, 5'd7,  32'h00001003, 1, 3'd1, 32'h80FF7F01, 1, 32'hFFFFFF80, 0, 1));
    vecs.push_back(mk(1, 1, 5'd7,  32'h00001003, 1, 3'd2, 32'h80FF7F01, 1, 32'h00000080, 0, 1));
    vecs.push_back(mk(1, 1, 5'd8,  32'h00000001, 1, 3'd1, 32'h80FF7F01, 1, 32'h0000007F, 0, 1));
    vecs.push_back(mk(1, 1, 5'd9,  32'h00000002, 1, 3'd1, 32'h80FF7F01, 1, 32'hFFFFFFFF, 0, 1));
    vecs.push_back(mk(1, 1, 5'd10, 32'h00000000, 1, 3'd2, 32'h80FF7F01, 1, 32'h00000001, 0, 1));
    vecs.push_back(mk(1, 1, 5'd11, 32'h00000002, 1, 3'd3, 32'h80FF7F01, 1, 32'hFFFF80FF, 0, 1));
    vecs.push_back(mk(1, 1, 5'd12, 32'h00000002, 1, 3'd4, 32'h80FF7F01, 1, 32'h000080FF, 0, 1));
    vecs.push_back(mk(1, 1, 5'd13, 32'h00000000, 1, 3'd3, 32'h80FF7F01, 1, 32'h00007F01, 0, 1));
    vecs.push_back(mk(1, 1, 5'd14, 32'h00000100, 1, 3'd0, 32'h80FF7F01, 1, 32'h80FF7F01, 0, 1));
    vecs.push_back(mk(1, 1, 5'd15, 32'h00000001, 1, 3'd3, 32'h80FF7F01, 0, 32'h0,        1, 0));
    vecs.push_back(mk(1, 1, 5'd16, 32'h00000002, 1, 3'd0, 32'h80FF7F01, 0, 32'h0,        1, 0));
    vecs.push_back(mk(1, 1, 5'd0,  32'hCAFEF00D, 0, 3'd0, 32'h0,        0, 32'hCAFEF00D, 0, 1));
    vecs.push_back(mk(1, 1, 5'd17, 32'h00000000, 1, 3'd7, 32'h80FF7F01, 1, 32'h80FF7F01, 0, 1));
    vecs.push_back(mk(1, 0, 5'd9,  32'h0BADBEEF, 0, 3'd0, 32'h0,        0, 32'h0BADBEEF, 0, 1));
    vecs.push_back(mk(1, 1, 5'd18, 32'h00000003, 1, 3'd4, 32'h80FF7F01, 0, 32'h0,        1, 0));
    vecs.push_back(mk(0, 1, 5'd19, 32'h55555555, 0, 3'd0, 32'h0,        0, 32'h0,        0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      sb.push_back(vecs[i]);
      cycle();
      e = sb.pop_front();
      chk($sformatf("v%0d_we", i), 32'(we), 32'(e.e_we));
      chk($sformatf("v%0d_adel", i), 32'(adel), 32'(e.e_adel));
      if (e.chk_data) begin
        chk($sformatf("v%0d_waddr", i), 32'(waddr), 32'(e.e_waddr));
        chk($sformatf("v%0d_wdata", i), wdata, e.e_wdata);
      end
      chk($sformatf("v%0d_retire", i), retire_cnt, exp_ret);
    end
    // 16 valid entries retired; the trailing bubble does not count.
    chk("table_retire_total", retire_cnt, 32'd16);

    // Stall holds the entry for 3 cycles, then it retires on release.
    alu(5'd3, 32'hDEADBEEF);
    cycle();
    r_hold = retire_cnt;
    alu(5'd4, 32'h11111111);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk($sformatf("stall%0d_we", k), 32'(we), 32'd1);
      chk($sformatf("stall%0d_waddr", k), 32'(waddr), 32'd3);
      chk($sformatf("stall%0d_wdata", k), wdata, 32'hDEADBEEF);
      chk($sformatf("stall%0d_ready", k), 32'(in_ready), 32'd0);
      chk($sformatf("stall%0d_retire", k), retire_cnt, r_hold);
    end
    idle_inputs();
    cycle();
    chk("stall_release_retire", retire_cnt, r_hold + 32'd1);
    chk("stall_release_we", 32'(we), 32'd0);
    chk("stall_release_ready", 32'(in_ready), 32'd1);

    // Flush with stall kills the held entry without retiring it.
    alu(5'd6, 32'h00000066);
    cycle();
    r_hold = retire_cnt;
    stall = 1'b1; flush = 1'b1;
    alu(5'd7, 32'h00000077);
    cycle();
    chk("flush_stall_we", 32'(we), 32'd0);
    chk("flush_stall_retire", retire_cnt, r_hold);
    idle_inputs();
    cycle();
    chk("flush_after_retire", retire_cnt, r_hold);

    // Flushed misaligned load raises no adel and does not retire.
    flush = 1'b1;
    in_valid = 1'b1; in_we = 1'b1; in_waddr = 5'd9; in_result = 32'h1;
    in_load = 1'b1; in_ldop = 3'd3; mem_rdata = 32'h12345678;
    cycle();
    chk("flush_ld_adel", 32'(adel), 32'd0);
    chk("flush_ld_we", 32'(we), 32'd0);
    idle_inputs();
    cycle();
    chk("flush_ld_retire", retire_cnt, r_hold);

    // Reset during a stall discards the held entry.
    alu(5'd21, 32'h21212121);
    cycle();
    stall = 1'b1;
    cycle();
    rst = 1'b1;
    cycle();
    chk("rst_stall_we", 32'(we), 32'd0);
    chk("rst_stall_retire", retire_cnt, 32'h0);
    rst = 1'b0;
    idle_inputs();
    cycle();
    chk("rst_stall_after_we", 32'(we), 32'd0);
    chk("rst_stall_after_retire", retire_cnt, 32'h0);

    // Counter wraps from all-ones to zero.
    alu(5'd2, 32'h00000002);
    cycle();
    idle_inputs();
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt_q;
    exp_ret = 32'hFFFF_FFFF;
    cycle();
    chk("wrap_retire", retire_cnt, 32'h0);
    chk("wrap_model", retire_cnt, exp_ret);

`ifdef WB_HILO_EN
    alu(5'd1, 32'h1);
    in_hilo_we = 1'b1; in_hi = 32'hA; in_lo = 32'hB;
    cycle();
    chk("hilo_hi", hi, 32'hA);
    chk("hilo_lo", lo, 32'hB);
    in_hilo_we = 1'b1; in_hi = 32'h5; in_lo = 32'h6; flush = 1'b1;
    cycle();
    chk("hilo_flush_hi", hi, 32'hA);
    chk("hilo_flush_lo", lo, 32'hB);
    idle_inputs();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
